// File: rtl/dmem_line_ctrl_pkg.sv
// Shared types and constants for the line-granular data-memory controller.
package dmem_line_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWb   = 2'd1,
        StFill = 2'd2,
        StResp = 2'd3
    } state_e;

    // Byte offset within a 16-byte line; the line index starts at this bit.
    localparam int unsigned LineOffset     = 4;
    localparam int unsigned DefaultLatency = 5;

endpackage

// File: rtl/dmem_line_ctrl_if.sv
// Miss-request / fill-response bundle between the data cache and the line controller.
interface dmem_line_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BITS_LINE  = 128
);

    logic                  req;
    logic                  req_wb;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [BITS_LINE-1:0]  wb_data;
    logic                  busy;
    logic                  fill_valid;
    logic [BITS_LINE-1:0]  fill_data;

    modport master (
        output req, req_wb, fill_addr, wb_addr, wb_data,
        input  busy, fill_valid, fill_data
    );

    modport slave (
        input  req, req_wb, fill_addr, wb_addr, wb_data,
        output busy, fill_valid, fill_data
    );

endinterface

// File: rtl/dmem_line_array.sv
// MEM_LINES x BITS_LINE backing store: synchronous write, registered read.
// Only the read register is reset; array contents survive reset.
module dmem_line_array #(
    parameter int unsigned BITS_LINE = 128,
    parameter int unsigned MEM_LINES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_LINES)-1:0] wr_idx,
    input  logic [BITS_LINE-1:0]         wr_data,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_LINES)-1:0] rd_idx,
    output logic [BITS_LINE-1:0]         rd_data
);

    logic [BITS_LINE-1:0] mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The read register doubles as the fill_data output, so it holds between fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/dmem_line_ctrl.sv
// Data-memory line controller: services a cache miss as optional writeback then fill,
// each access taking LATENCY cycles, and returns the line with a one-cycle strobe.
module dmem_line_ctrl
    import dmem_line_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BITS_LINE  = 128,
    parameter int unsigned MEM_LINES  = 1024,
    parameter int unsigned LATENCY    = DefaultLatency
) (
    input logic             clk,
    input logic             rst_n,
    dmem_line_ctrl_if.slave bus
);

    localparam int unsigned IdxW = $clog2(MEM_LINES);
    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    state_e               state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      fill_idx;
    logic [IdxW-1:0]      wb_idx;
    logic [BITS_LINE-1:0] wb_line;
    logic                 busy_q;
    logic                 fill_valid_q;
    logic                 wr_en;
    logic                 rd_en;
    logic                 unused_addr_bits;

    // Lines alias modulo MEM_LINES; offset and upper address bits play no part.
    assign unused_addr_bits = ^{bus.fill_addr[ADDR_WIDTH-1:LineOffset+IdxW],
                                bus.fill_addr[LineOffset-1:0],
                                bus.wb_addr[ADDR_WIDTH-1:LineOffset+IdxW],
                                bus.wb_addr[LineOffset-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cnt          <= '0;
            fill_idx     <= '0;
            wb_idx       <= '0;
            wb_line      <= '0;
            busy_q       <= 1'b0;
            fill_valid_q <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req) begin
                        fill_idx <= bus.fill_addr[LineOffset +: IdxW];
                        wb_idx   <= bus.wb_addr[LineOffset +: IdxW];
                        wb_line  <= bus.wb_data;
                        cnt      <= CntLoad;
                        busy_q   <= 1'b1;
                        state    <= bus.req_wb ? StWb : StFill;
                    end
                end
                StWb: begin
                    if (cnt == '0) begin
                        cnt   <= CntLoad;
                        state <= StFill;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StFill: begin
                    if (cnt == '0) begin
                        fill_valid_q <= 1'b1;
                        state        <= StResp;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StResp: begin
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Array strobes fire on the edge that ends each access.
    assign wr_en = (state == StWb) && (cnt == '0);
    assign rd_en = (state == StFill) && (cnt == '0);

    dmem_line_array #(
        .BITS_LINE (BITS_LINE),
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wb_idx),
        .wr_data (wb_line),
        .rd_en   (rd_en),
        .rd_idx  (fill_idx),
        .rd_data (bus.fill_data)
    );

    assign bus.busy       = busy_q;
    assign bus.fill_valid = fill_valid_q;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Bench for dmem_line_ctrl: timing/data model checked every cycle, plus directed literals.
module tb_dmem_line_ctrl;

    localparam int unsigned Lat   = 5;
    localparam int unsigned Lines = 1024;

    localparam logic [127:0] P3   = 128'h33221100_99887766_55443322_11009988;
    localparam logic [127:0] P1   = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] Dead = {4{32'hDEADBEEF}};
    localparam logic [127:0] Junk = {4{32'hBAD0BAD0}};
    localparam logic [127:0] P7   = 128'h70717273_74757677_78797a7b_7c7d7e7f;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_line_ctrl_if #(.ADDR_WIDTH(32), .BITS_LINE(128)) bus ();
    dmem_line_ctrl_if #(.ADDR_WIDTH(32), .BITS_LINE(128)) bus1 ();

    dmem_line_ctrl #(
        .ADDR_WIDTH (32),
        .BITS_LINE  (128),
        .MEM_LINES  (Lines),
        .LATENCY    (Lat)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmem_line_ctrl #(
        .ADDR_WIDTH (32),
        .BITS_LINE  (128),
        .MEM_LINES  (Lines),
        .LATENCY    (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_line(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the LATENCY=5 instance: one outstanding miss described by its edge times.
    logic [127:0] mem_model [Lines];
    bit           mem_known [Lines];
    bit           pend     = 1'b0;
    int           t_acc    = 0;
    int           t_wr     = 0;
    int           t_fv     = 0;
    bit           m_wb     = 1'b0;
    int           m_widx   = 0;
    int           m_fidx   = 0;
    logic [127:0] m_wdata  = '0;
    logic [127:0] cur_fd   = '0;
    bit           fd_known = 1'b1;

    // Edge index of the current posedge is cyc + 1 (cyc updates non-blocking here).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            cur_fd   <= '0;
            fd_known <= 1'b1;
        end else begin
            if (pend && m_wb && (cyc + 1 == t_wr)) begin
                mem_model[m_widx] <= m_wdata;
                mem_known[m_widx] <= 1'b1;
            end
            if (pend && (cyc + 1 == t_fv)) begin
                cur_fd   <= mem_model[m_fidx];
                fd_known <= mem_known[m_fidx];
            end
            if (bus.req === 1'b1 && (!pend || cyc + 1 >= t_fv + 2)) begin
                pend    <= 1'b1;
                t_acc   <= cyc + 1;
                t_wr    <= cyc + 1 + Lat;
                t_fv    <= cyc + 1 + (bus.req_wb ? 2 : 1) * Lat;
                m_wb    <= bus.req_wb;
                m_widx  <= (bus.wb_addr >> 4) % Lines;
                m_fidx  <= (bus.fill_addr >> 4) % Lines;
                m_wdata <= bus.wb_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_int("busy", longint'(bus.busy), longint'(pend && cyc >= t_acc && cyc <= t_fv));
            check_int("fill_valid", longint'(bus.fill_valid), longint'(pend && cyc == t_fv));
            if (fd_known) check_line("fill_data", bus.fill_data, cur_fd);
        end
    end

    task automatic start(input bit sel, input bit wb, input logic [31:0] waddr,
                         input logic [127:0] wdata, input logic [31:0] faddr, output int t);
        @(posedge clk);
        #2;
        if (sel) begin
            bus1.req = 1'b1; bus1.req_wb = wb; bus1.wb_addr = waddr;
            bus1.wb_data = wdata; bus1.fill_addr = faddr;
        end else begin
            bus.req = 1'b1; bus.req_wb = wb; bus.wb_addr = waddr;
            bus.wb_data = wdata; bus.fill_addr = faddr;
        end
        @(posedge clk);
        #1;
        t = cyc;
        #1;
        if (sel) bus1.req = 1'b0;
        else     bus.req  = 1'b0;
    endtask

    task automatic wait_fv(input bit sel, input int t, output int lat,
                           output logic [127:0] data);
        bit seen = 1'b0;
        lat  = -1;
        data = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? bus1.fill_valid : bus.fill_valid) === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t;
                data = sel ? bus1.fill_data : bus.fill_data;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL fill_valid_timeout: got none expected strobe (dut %0d)", sel);
        end
    endtask

    task automatic issue(input bit sel, input bit wb, input logic [31:0] waddr,
                         input logic [127:0] wdata, input logic [31:0] faddr,
                         output int lat, output logic [127:0] data);
        int t;
        start(sel, wb, waddr, wdata, faddr, t);
        wait_fv(sel, t, lat, data);
    endtask

    initial begin
        int           lat;
        int           t;
        int           f1;
        int           extra;
        logic [127:0] d;

        bus.req = 1'b0;  bus.req_wb = 1'b0;  bus.fill_addr = '0;  bus.wb_addr = '0;
        bus.wb_data = '0;
        bus1.req = 1'b0; bus1.req_wb = 1'b0; bus1.fill_addr = '0; bus1.wb_addr = '0;
        bus1.wb_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_int("reset_busy", longint'(bus.busy), 0);
        check_int("reset_fill_valid", longint'(bus.fill_valid), 0);
        check_line("reset_fill_data", bus.fill_data, '0);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Preload lines 3 and 1 through writeback+fill of the same line.
        issue(1'b0, 1'b1, 32'h30, P3, 32'h30, lat, d);
        check_int("preload3_lat", lat, 10);
        check_line("preload3_data", d, P3);
        issue(1'b0, 1'b1, 32'h10, P1, 32'h10, lat, d);
        check_line("preload1_data", d, P1);

        issue(1'b0, 1'b0, 32'h0, '0, 32'h30, lat, d);
        check_int("fill3_lat", lat, 5);
        check_line("fill3_data", d, P3);
        @(negedge clk);
        check_int("busy_after_resp", longint'(bus.busy), 0);

        issue(1'b0, 1'b1, 32'h40, Dead, 32'h10, lat, d);
        check_int("wbfill_lat", lat, 10);
        check_line("wbfill_data", d, P1);
        issue(1'b0, 1'b0, 32'h0, '0, 32'h40, lat, d);
        check_line("dead_readback", d, Dead);

        issue(1'b0, 1'b1, 32'h20, 128'h1, 32'h20, lat, d);
        check_line("wb_eq_fill", d, 128'h1);

        // Inputs wiggled while busy must not disturb the captured request.
        start(1'b0, 1'b0, 32'h0, '0, 32'h30, t);
        @(posedge clk);
        #2;
        bus.req = 1'b1; bus.req_wb = 1'b1; bus.fill_addr = 32'h40;
        bus.wb_addr = 32'h30; bus.wb_data = Junk;
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        wait_fv(1'b0, t, lat, d);
        check_int("ignore_lat", lat, 5);
        check_line("ignore_data", d, P3);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.fill_valid === 1'b1) extra++;
        end
        check_int("ignore_no_second_fv", extra, 0);

        issue(1'b1, 1'b1, 32'h70, P7, 32'h70, lat, d);
        check_int("lat1_wbfill_lat", lat, 2);
        check_line("lat1_wbfill_data", d, P7);
        issue(1'b1, 1'b0, 32'h0, '0, 32'h70, lat, d);
        check_int("lat1_fill_lat", lat, 1);
        check_line("lat1_fill_data", d, P7);

        // Reset in the third WB cycle: request lost, victim line untouched.
        start(1'b0, 1'b1, 32'h30, Junk, 32'h50, t);
        while (cyc < t + 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midwb_busy", longint'(bus.busy), 0);
        check_int("midwb_fill_valid", longint'(bus.fill_valid), 0);
        check_line("midwb_fill_data", bus.fill_data, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 32'h0, '0, 32'h30, lat, d);
        check_line("midwb_line_intact", d, P3);

        issue(1'b0, 1'b0, 32'h0, '0, 32'h4030, lat, d);
        check_int("alias_lat", lat, 5);
        check_line("alias_data", d, P3);

        // Held req: second accept is the first IDLE edge after RESP.
        @(posedge clk);
        #2;
        bus.req = 1'b1; bus.req_wb = 1'b0; bus.fill_addr = 32'h40;
        @(posedge clk);
        #1;
        t = cyc;
        wait_fv(1'b0, t, lat, d);
        f1 = cyc;
        check_int("b2b_first_lat", lat, 5);
        @(posedge clk);
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        wait_fv(1'b0, f1, lat, d);
        check_int("b2b_gap", lat, 7);
        check_line("b2b_data", d, Dead);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_line_ctrl.md
# dmem_line_ctrl

Line-granular data-memory controller sitting directly downstream of the data cache: it services cache misses by optionally writing back a dirty 128-bit victim line and then fetching the requested 128-bit line from a backing array, with a fixed, parameterised access latency. It turns the cache's single miss request into a writeback-then-fill sequence and returns the fill line with a one-cycle valid strobe. It owns the main data-memory array for the processor.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- BITS_LINE, 128, line width (16 bytes; byte offset is addr[3:0])
- MEM_LINES, 1024, number of lines in the backing array (power of two)
- LATENCY, 5, cycles per memory access (writeback or fill), legal range 1..15

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  miss request, sampled only in IDLE
- req_wb  in  1  victim is dirty, write back before fill (sampled with req)
- fill_addr  in  ADDR_WIDTH  byte address of line to fetch
- wb_addr  in  ADDR_WIDTH  byte address of victim line
- wb_data  in  BITS_LINE  victim line contents
- busy  out  1  request in progress; cache must hold its miss
- fill_valid  out  1  one-cycle strobe, fill_data valid
- fill_data  out  BITS_LINE  fetched line

## Operation
- States: IDLE, WB, FILL, RESP.
- IDLE: if req=1 at a rising edge, capture fill_addr, wb_addr, wb_data, req_wb into internal registers; go to WB if req_wb=1, else FILL; load latency counter with LATENCY-1.
- WB: counter decrements each cycle; on the edge where counter=0, write captured wb_data to array[wb index], go to FILL, reload counter.
- FILL: counter decrements; on the edge where counter=0, register array[fill index] into fill_data, go to RESP.
- RESP: fill_valid=1, busy=1 for exactly one cycle; next state IDLE unconditionally (req ignored in RESP).
- Line index = addr[3+log2(MEM_LINES) : 4]; upper bits ignored (addresses alias/wrap modulo MEM_LINES lines); addr[3:0] ignored.
- Inputs other than clk/rst_n are ignored outside IDLE; changes during busy have no effect.
- wb index = fill index: writeback completes first, fill returns the just-written wb_data.
- Reset: state IDLE, counter 0, busy=0, fill_valid=0, fill_data=0, captured registers 0. Array contents are not altered by reset. Reset mid-WB before the write edge: array unchanged; request lost, cache must re-issue.

## Timing
- busy is a registered output: 1 from the edge after acceptance through the RESP cycle inclusive; 0 in IDLE.
- Accept at edge T: no writeback -> fill_valid high in cycle after edge T+LATENCY; with writeback -> after edge T+2*LATENCY.
- Back-to-back: new req may be accepted at the first edge with state IDLE, i.e. the edge ending RESP is not an accept edge; earliest next accept is one cycle after fill_valid.
- fill_data holds its value after RESP until the next fill completes.
- LATENCY=1: WB and FILL each last one cycle.

## Structure
- Shared package: state encoding enum (IDLE, WB, FILL, RESP), line-offset constant (4), default LATENCY.
- Counter width $clog2(LATENCY+1); no arithmetic wrap (reload before underflow).
- One natural sub-module: dmem_line_array (synchronous-write, registered-read MEM_LINES x BITS_LINE array, optional $readmemh init for simulation).

## Test plan
- Preload line 3 = 128'h33221100_99887766_55443322_11009988; req=1, req_wb=0, fill_addr=32'h30 -> busy next cycle, fill_valid one cycle after edge T+5 with that data, busy low following cycle.
- req=1, req_wb=1, wb_addr=32'h40, wb_data=128'hDEADBEEF_...(all 0xDEADBEEF), fill_addr=32'h10 -> fill_valid after edge T+10; subsequent fill of 32'h40 returns 0xDEADBEEF pattern.
- wb_addr=fill_addr=32'h20, wb_data=128'h1 -> fill_data=128'h1.
- Change fill_addr and pulse req during busy -> ignored; returned line matches originally captured address; no second fill_valid.
- Assert rst_n=0 at cycle 3 of WB -> busy, fill_valid, fill_data 0 immediately; wb target line unchanged afterwards.
- fill_addr=32'h4030 with MEM_LINES=1024 -> aliases line 3 (index 0x403 mod 1024); LATENCY=1 build -> fill_valid after edge T+1.
